// File: rtl/unison_frame_readout.sv
// Unison frame readout: synchronised event counting on NUM_CORES I/Q channels,
// frame snapshot and LANES-bit serial readout. Optional macro: UNISON_SATURATE_EN.

module unison_chan_cnt #(
  parameter int CNT_W = 12
) (
  input  logic             clk_master,
  input  logic             rstb,
  input  logic             ev_edge,
  input  logic             up,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_o
);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef UNISON_SATURATE_EN
  localparam logic [CNT_W-1:0] MAXV = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] MINV = {1'b1, {(CNT_W-1){1'b0}}};
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d, base;

  // A snapshot clears the counter but a coincident event still lands on the fresh value
  always_comb begin
    base  = clr ? '0 : cnt_q;
    cnt_d = base;
    if (ev_edge) begin
`ifdef UNISON_SATURATE_EN
      if (up && base != MAXV)       cnt_d = base + ONE;
      else if (!up && base != MINV) cnt_d = base - ONE;
`else
      cnt_d = up ? base + ONE : base - ONE;
`endif
    end
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

module unison_frame_readout #(
  parameter int NUM_CORES = 8,
  parameter int CNT_W     = 12,
  parameter int LANES     = 2
) (
  input  logic                 clk_master,
  input  logic                 rstb,
  input  logic                 ud_en,
  input  logic [NUM_CORES-1:0] ev_I,
  input  logic [NUM_CORES-1:0] ev_Q,
  input  logic [NUM_CORES-1:0] dir_I,
  input  logic [NUM_CORES-1:0] dir_Q,
  input  logic                 frame_start,
  output logic [LANES-1:0]     read_out_I,
  output logic [LANES-1:0]     read_out_Q,
  output logic                 frame_valid,
  output logic                 overrun
);
  localparam int SR_W      = NUM_CORES * CNT_W;
  localparam int FRAME_CYC = SR_W / LANES;
  localparam int CW        = $clog2(FRAME_CYC + 1);
  localparam int NCH       = 2 * NUM_CORES;
  localparam int NS        = NCH + 1;

  logic [NS-1:0] sync1_q, sync2_q, sync3_q, edges;
  logic [NCH-1:0] ev_edge, up;
  logic [NCH-1:0][CNT_W-1:0] cnt;
  logic [SR_W-1:0] snap_i, snap_q, sr_i_q, sr_q_q;
  logic [CW-1:0] cyc_q;
  logic valid_q, ovr_q, fs_edge, busy, take;

  // Bit NS-1 is frame_start; below it Q channels then I channels
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= {frame_start, ev_Q, ev_I};
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign edges   = sync2_q & ~sync3_q;
  assign fs_edge = edges[NS-1];
  assign ev_edge = edges[NCH-1:0];
  assign up      = {NCH{~ud_en}} | {dir_Q, dir_I};

  // The last frame cycle counts as idle so frames can run back to back
  assign busy = valid_q && (cyc_q != '0);
  assign take = fs_edge && !busy;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    unison_chan_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_master (clk_master),
      .rstb       (rstb),
      .ev_edge    (ev_edge[c]),
      .up         (up[c]),
      .clr        (take),
      .cnt_o      (cnt[c])
    );
  end

  always_comb begin
    snap_i = '0;
    snap_q = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      snap_i[SR_W-1-c*CNT_W -: CNT_W] = cnt[c];
      snap_q[SR_W-1-c*CNT_W -: CNT_W] = cnt[NUM_CORES+c];
    end
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      sr_i_q  <= '0;
      sr_q_q  <= '0;
      cyc_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (fs_edge && busy) ovr_q <= 1'b1;
      if (take) begin
        sr_i_q  <= snap_i;
        sr_q_q  <= snap_q;
        cyc_q   <= CW'(FRAME_CYC - 1);
        valid_q <= 1'b1;
      end else if (valid_q) begin
        if (cyc_q == '0) begin
          valid_q <= 1'b0;
        end else begin
          cyc_q  <= cyc_q - 1'b1;
          sr_i_q <= sr_i_q << LANES;
          sr_q_q <= sr_q_q << LANES;
        end
      end
    end
  end

  assign read_out_I  = valid_q ? sr_i_q[SR_W-1 -: LANES] : '0;
  assign read_out_Q  = valid_q ? sr_q_q[SR_W-1 -: LANES] : '0;
  assign frame_valid = valid_q;
  assign overrun     = ovr_q;
endmodule

// File: tb/tb_unison_frame_readout.sv
// Directed + randomized bench for unison_frame_readout (NUM_CORES=2, CNT_W=4, LANES=2).
module tb_unison_frame_readout;
  logic       clk_master = 1'b0;
  logic       rstb = 1'b0;
  logic       ud_en = 1'b0;
  logic [1:0] ev_I = '0, ev_Q = '0, dir_I = '0, dir_Q = '0;
  logic       frame_start = 1'b0;
  logic [1:0] read_out_I, read_out_Q;
  logic       frame_valid, overrun;

  int ncmp = 0;
  int nfail = 0;
  int m [2][2];    // model counts [path 0=I,1=Q][channel]
  bit ovr_exp = 0;

  unison_frame_readout #(.NUM_CORES(2), .CNT_W(4), .LANES(2)) dut (
    .clk_master(clk_master), .rstb(rstb), .ud_en(ud_en),
    .ev_I(ev_I), .ev_Q(ev_Q), .dir_I(dir_I), .dir_Q(dir_Q),
    .frame_start(frame_start), .read_out_I(read_out_I), .read_out_Q(read_out_Q),
    .frame_valid(frame_valid), .overrun(overrun)
  );

  always #5 clk_master = ~clk_master;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_event(input int p, input int c, input bit up);
    int v;
    v = m[p][c] + (up ? 1 : -1);
`ifdef UNISON_SATURATE_EN
    if (v > 7)  v = 7;
    if (v < -8) v = -8;
`endif
    m[p][c] = v;
  endfunction

  function automatic logic [7:0] frame_vec(input int p);
    logic [3:0] c0, c1;
    c0 = 4'(m[p][0]);
    c1 = 4'(m[p][1]);
    return {c0, c1};
  endfunction

  // One clean event pulse; direction held for the whole pulse
  task automatic pulse(input int p, input int c, input bit d, input bit ud);
    @(negedge clk_master);
    ud_en = ud;
    if (p == 0) begin dir_I[c] = d; ev_I[c] = 1'b1; end
    else        begin dir_Q[c] = d; ev_Q[c] = 1'b1; end
    repeat (3) @(negedge clk_master);
    if (p == 0) ev_I[c] = 1'b0; else ev_Q[c] = 1'b0;
    repeat (3) @(negedge clk_master);
    model_event(p, c, (ud == 1'b0) || d);
  endtask

  // Request a frame and check all FRAME_CYC beats; optionally inject an overrun
  // edge during the frame or an I0 event coincident with the snapshot.
  task automatic do_frame(input string tag, input bit ovr, input bit coin);
    logic [7:0] vi, vq;
    logic [1:0] ei, eq;
    vi = frame_vec(0);
    vq = frame_vec(1);
    m = '{default: 0};
    @(negedge clk_master);
    frame_start = 1'b1;
    if (coin) begin ud_en = 1'b0; ev_I[0] = 1'b1; end
    repeat (2) @(posedge clk_master);
    #1 frame_start = 1'b0;
    ev_I[0] = 1'b0;
    if (coin) model_event(0, 0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_master); #1;
      ei = vi[7-2*c -: 2];
      eq = vq[7-2*c -: 2];
      check({tag, "_valid"}, frame_valid, 1'b1);
      check({tag, "_I"}, read_out_I, ei);
      check({tag, "_Q"}, read_out_Q, eq);
      if (ovr && c == 0) frame_start = 1'b1;
    end
    if (ovr) ovr_exp = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_master); #1;
      check({tag, "_idle_valid"}, frame_valid, 1'b0);
      check({tag, "_idle_I"}, read_out_I, 2'b00);
      check({tag, "_idle_Q"}, read_out_Q, 2'b00);
    end
    frame_start = 1'b0;
    check({tag, "_overrun"}, overrun, ovr_exp);
    repeat (3) @(negedge clk_master);
  endtask

  initial begin
    m = '{default: 0};
    #1;
    check("rst_valid", frame_valid, 1'b0);
    check("rst_I", read_out_I, 2'b00);
    check("rst_Q", read_out_Q, 2'b00);
    check("rst_ovr", overrun, 1'b0);
    repeat (3) @(negedge clk_master);
    rstb = 1'b1;
    repeat (6) @(posedge clk_master);
    #1 check("idle_valid", frame_valid, 1'b0);

    // Up-count
    repeat (3) pulse(0, 0, 1'b0, 1'b0);
    pulse(1, 1, 1'b0, 1'b0);
    do_frame("up", 1'b0, 1'b0);

    // Down-count, then an empty frame
    pulse(0, 1, 1'b0, 1'b1);
    pulse(0, 1, 1'b0, 1'b1);
    do_frame("down", 1'b0, 1'b0);
    do_frame("empty", 1'b0, 1'b0);

    // Saturation / wrap
    repeat (9) pulse(1, 0, 1'b1, 1'b0);
    do_frame("sat", 1'b0, 1'b0);

    // Overrun
    pulse(0, 1, 1'b1, 1'b0);
    do_frame("ovr", 1'b1, 1'b0);

    // Coincident event lands in the next frame
    do_frame("coin", 1'b0, 1'b1);
    do_frame("coin_next", 1'b0, 1'b0);

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(12, 2);
      for (int k = 0; k < n; k++)
        pulse($urandom_range(1, 0), $urandom_range(1, 0), 1'($urandom), 1'($urandom));
      do_frame("rand", 1'b0, 1'b0);
    end

    // Mid-frame asynchronous reset
    pulse(0, 0, 1'b1, 1'b0);
    pulse(1, 0, 1'b1, 1'b0);
    @(negedge clk_master);
    frame_start = 1'b1;
    repeat (3) @(posedge clk_master);
    #1 check("mid_valid", frame_valid, 1'b1);
    frame_start = 1'b0;
    @(posedge clk_master);
    #2 rstb = 1'b0;
    #1;
    check("mrst_valid", frame_valid, 1'b0);
    check("mrst_I", read_out_I, 2'b00);
    check("mrst_Q", read_out_Q, 2'b00);
    check("mrst_ovr", overrun, 1'b0);
    m = '{default: 0};
    ovr_exp = 1'b0;
    repeat (2) @(negedge clk_master);
    rstb = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk_master); #1;
      check("post_rst_valid", frame_valid, 1'b0);
      check("post_rst_I", read_out_I, 2'b00);
    end
    do_frame("post_rst", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
